// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: PC handshake, program memory port, control inputs and instruction register outputs.
// master = fetch unit, slave = surrounding core (PC, program memory, execute).
interface instruction_fetch_unit_if;
    logic [12:0] pc_in;
    logic        pc_incr_en;
    logic [12:0] pmem_addr;
    logic        pmem_rd_en;
    logic [13:0] pmem_data;
    logic        flush;
    logic        sleep_req;
    logic        wake;
    logic [1:0]  q_phase;
    logic [13:0] instr_out;
    logic [12:0] instr_pc;
    logic        instr_valid;
    logic        asleep;

    modport master (
        input  pc_in, pmem_data, flush, sleep_req, wake,
        output pc_incr_en, pmem_addr, pmem_rd_en, q_phase,
               instr_out, instr_pc, instr_valid, asleep
    );

    modport slave (
        output pc_in, pmem_data, flush, sleep_req, wake,
        input  pc_incr_en, pmem_addr, pmem_rd_en, q_phase,
               instr_out, instr_pc, instr_valid, asleep
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PIC16-style fetch stage: Q1..Q4 sequencer, instruction register, flush-to-NOP and SLEEP/wake.
// One instruction cycle (4 clocks) fetch-to-IR latency; no backpressure, the core consumes every cycle.
module instruction_fetch_unit #(
    parameter logic [13:0] NOP_WORD = 14'h0000
) (
    input  logic                          clk,
    input  logic                          rst,
    instruction_fetch_unit_if.master      bus
);

    typedef enum logic {ST_RUN = 1'b0, ST_SLEEP = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  q_phase_q, q_phase_d;
    logic [12:0] fetch_pc_q, fetch_pc_d;
    logic [13:0] fetch_buf_q, fetch_buf_d;
    logic        flush_pending_q, flush_pending_d;
    logic [13:0] instr_out_q, instr_out_d;
    logic [12:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    // State register (synchronous reset overrides any phase, including a pending flush)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            q_phase_q       <= 2'd0;
            fetch_pc_q      <= 13'd0;
            fetch_buf_q     <= NOP_WORD;
            flush_pending_q <= 1'b0;
            instr_out_q     <= NOP_WORD;
            instr_pc_q      <= 13'd0;
            instr_valid_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            q_phase_q       <= q_phase_d;
            fetch_pc_q      <= fetch_pc_d;
            fetch_buf_q     <= fetch_buf_d;
            flush_pending_q <= flush_pending_d;
            instr_out_q     <= instr_out_d;
            instr_pc_q      <= instr_pc_d;
            instr_valid_q   <= instr_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (q_phase_q == 2'd3 && bus.sleep_req) state_d = ST_SLEEP;
            ST_SLEEP: if (bus.wake) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Phase sequencing and datapath next values
    always_comb begin
        q_phase_d       = q_phase_q;
        fetch_pc_d      = fetch_pc_q;
        fetch_buf_d     = fetch_buf_q;
        flush_pending_d = flush_pending_q;
        instr_out_d     = instr_out_q;
        instr_pc_d      = instr_pc_q;
        instr_valid_d   = instr_valid_q;

        if (state_q == ST_RUN) begin
            q_phase_d = q_phase_q + 2'd1;
            case (q_phase_q)
                2'd0: begin
                    fetch_pc_d      = bus.pc_in;
                    flush_pending_d = flush_pending_q | bus.flush;
                end
                2'd1: begin
                    fetch_buf_d     = bus.pmem_data;
                    flush_pending_d = flush_pending_q | bus.flush;
                end
                2'd2: begin
                    flush_pending_d = flush_pending_q | bus.flush;
                end
                default: begin
                    instr_pc_d      = fetch_pc_q;
                    flush_pending_d = 1'b0;
                    if (bus.flush || flush_pending_q || bus.sleep_req) begin
                        instr_out_d   = NOP_WORD;
                        instr_valid_d = 1'b0;
                    end else begin
                        instr_out_d   = fetch_buf_q;
                        instr_valid_d = 1'b1;
                    end
                end
            endcase
        end else begin
            // Asleep: phase parked at Q1 so a wake resumes with a fresh fetch
            q_phase_d       = 2'd0;
            flush_pending_d = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        bus.pmem_addr   = bus.pc_in;
        bus.pmem_rd_en  = (state_q == ST_RUN) && (q_phase_q == 2'd0);
        bus.pc_incr_en  = (state_q == ST_RUN) && (q_phase_q == 2'd1);
        bus.q_phase     = q_phase_q;
        bus.instr_out   = instr_out_q;
        bus.instr_pc    = instr_pc_q;
        bus.instr_valid = instr_valid_q;
        bus.asleep      = (state_q == ST_SLEEP);
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage that consumes the program counter's pc_out and feeds the execute/decode logic.
- Generates the PIC16F four-phase Q1..Q4 instruction cycle.
- Reads 14-bit words from synchronous program memory and drives pc_incr_en back to the program counter.
- Holds the instruction register, inserts forced NOPs on flush (taken jumps, skips), and implements SLEEP/wake sequencing.

Parameters:
- NOP_WORD, 14'h0000, instruction word loaded on flush and at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pc_in  in  13  current PC from program counter
- pc_incr_en  out  1  request PC+1; combinational, high only in Q2 of an active fetch
- pmem_addr  out  13  program memory address
- pmem_rd_en  out  1  program memory read strobe
- pmem_data  in  14  read data, valid the clock after pmem_rd_en
- flush  in  1  discard the word being fetched this instruction cycle
- sleep_req  in  1  enter sleep at end of current instruction cycle
- wake  in  1  leave sleep
- q_phase  out  2  0..3 = Q1..Q4
- instr_out  out  14  instruction register
- instr_pc  out  13  address instr_out was fetched from
- instr_valid  out  1  instr_out is a real fetched word (0 = forced NOP)
- asleep  out  1  high while in SLEEP state

Behaviour:
- Reset:
  - q_phase=0 (Q1), instr_out=NOP_WORD, instr_pc=0, instr_valid=0, asleep=0.
  - Fetch buffer=NOP_WORD, flush_pending=0, state RUN.
  - Reset takes effect mid-cycle regardless of phase; the pending flush is cleared.
- States:
  - RUN: q_phase advances 0→1→2→3→0 every clock.
  - SLEEP: q_phase held at 0; no memory reads; pc_incr_en=0.
- Q1 (RUN): pmem_addr=pc_in, pmem_rd_en=1; fetch_pc<=pc_in. pmem_addr=pc_in in all phases; pmem_rd_en is high only in Q1.
- Q2 (RUN): fetch_buf<=pmem_data; pc_incr_en=1. The PC updates at the end of Q2.
- Q3: no fetch action.
- Q4 clock edge (RUN):
  - instr_pc<=fetch_pc.
  - If flush or flush_pending: instr_out<=NOP_WORD, instr_valid<=0.
  - Else: instr_out<=fetch_buf, instr_valid<=1.
  - flush_pending<=0.
  - If sleep_req: enter SLEEP, asleep<=1, instr_out<=NOP_WORD, instr_valid<=0.
- Flush:
  - flush high in Q1..Q3 sets flush_pending.
  - flush high in Q4 is applied directly at that edge.
  - Multiple flush pulses in one instruction cycle act as one.
  - flush does not suppress the fetch or pc_incr_en: a taken jump issued by execute in Q4 overrides the PC, and the next Q1 fetches the target.
  - Result: two-cycle branches — one forced-NOP cycle.
- Pipeline: an instruction fetched in cycle N appears on instr_out from the Q4 edge of cycle N and is executed during cycle N+1.
  - The first instruction cycle after reset executes NOP_WORD while fetching address 0.
- Sleep:
  - sleep_req is sampled only at the Q4 edge.
  - In SLEEP, flush is ignored and flush_pending stays 0.
  - wake high in SLEEP: next clock asleep<=0, state RUN, q_phase stays 0, so the following clock is Q1 with a fetch from pc_in.
  - The instruction fetched before sleep is discarded, so the first post-wake cycle executes NOP.
  - sleep_req and wake both high at a Q4 edge: sleep is entered, then wake is honoured next clock.
- Address width: 13-bit pass-through, no arithmetic. PC wrap (1FFF→0000) is handled upstream; fetch simply follows pc_in.

Test Plan:
- Reset release, pc_in increments 0,1,2 on pc_incr_en; memory[0]=14'h3001, [1]=14'h3002:
  - q_phase cycles 0,1,2,3.
  - pc_incr_en high only when q_phase=1.
  - pmem_rd_en only when q_phase=0.
  - instr_out=0000/valid=0 until the first Q4 edge, then 3001/valid=1/instr_pc=0, then 3002/instr_pc=1.
- Flush pulse in Q2 of cycle fetching addr 5:
  - instr_out=NOP_WORD and instr_valid=0 after that Q4.
  - The next cycle loads the word at pc_in (jump target, e.g. 0x0123) with instr_pc=0x0123.
- Flush in Q4 only, and flush in both Q1 and Q3 of the same cycle: each yields exactly one NOP cycle.
- sleep_req at Q4:
  - asleep=1, q_phase frozen at 0, no pmem_rd_en/pc_incr_en for 20 clocks.
  - Pulse wake: asleep falls, next clock pmem_rd_en with pmem_addr=pc_in.
  - First post-wake instr_valid=0.
- rst asserted in Q3 with flush_pending set: next clock all reset values; after release the first Q4 loads the word from addr 0 with valid=1.
- pc_in=0x1FFF wraps to 0x0000: instr_pc shows 1FFF then 0000 on consecutive cycles, data unchanged.
